// File: rtl/vadd16_operand_loader.sv
// rtl/vadd16_operand_loader.sv - fetches two lane-packed operand vectors from a narrow
// memory port, hands them to the vector adder and reports its overflow flag.
module vadd16_operand_loader #(
  parameter int ADDR_W = 16,
  parameter int LANE_W = 16,
  parameter int LANES  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go,
  input  logic [ADDR_W-1:0]         base1,
  input  logic [ADDR_W-1:0]         base2,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [LANE_W-1:0]         mem_rdata,
  output logic [LANES*LANE_W-1:0]   Inval1,
  output logic [LANES*LANE_W-1:0]   Inval2,
  output logic                      start,
  input  logic                      done,
  input  logic                      Overflw,
  output logic                      busy,
  output logic                      ovf,
  output logic                      complete
);

  localparam int LIDX_W = $clog2(LANES);
  localparam int K_W    = LIDX_W + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(2*LANES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ISSUE} state_e;

  state_e                   state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [ADDR_W-1:0]        b1_q, b1_d, b2_q, b2_d;
  logic                     cap_v_q;
  logic [K_W-1:0]           cap_k_q;
  logic [LANES*LANE_W-1:0]  inval1_q, inval2_q;
  logic                     ovf_q, ovf_d;
  logic                     complete_q, complete_d;
  logic                     accept, finish;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = FETCH;
      FETCH:   if (k_q == K_LAST) state_d = DRAIN;
      DRAIN:   state_d = ISSUE;
      ISSUE:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    start    = 1'b0;
    busy     = (state_q != IDLE);
    accept   = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE:  accept = go;
      FETCH: begin
        mem_rd   = 1'b1;
        // upper half of the read sequence walks operand 2
        mem_addr = (k_q[LIDX_W] ? b2_q : b1_q) + ADDR_W'(k_q[LIDX_W-1:0]);
      end
      ISSUE: begin
        start  = 1'b1;
        finish = done;
      end
      default: ;
    endcase
  end

  always_comb begin
    k_d        = (state_q == FETCH && k_q != K_LAST) ? k_q + K_W'(1) : '0;
    b1_d       = accept ? base1 : b1_q;
    b2_d       = accept ? base2 : b2_q;
    ovf_d      = ovf_q;
    if (accept) ovf_d = 1'b0;
    else if (finish) ovf_d = Overflw;
    complete_d = finish;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      cap_v_q    <= 1'b0;
      cap_k_q    <= '0;
      inval1_q   <= '0;
      inval2_q   <= '0;
      ovf_q      <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      ovf_q      <= ovf_d;
      complete_q <= complete_d;
      // read data arrives one cycle after its strobe; remember which lane it belongs to
      cap_v_q    <= mem_rd;
      cap_k_q    <= k_q;
      for (int i = 0; i < LANES; i++) begin
        if (cap_v_q && cap_k_q[LIDX_W-1:0] == LIDX_W'(i)) begin
          if (cap_k_q[LIDX_W]) inval2_q[i*LANE_W +: LANE_W] <= mem_rdata;
          else                 inval1_q[i*LANE_W +: LANE_W] <= mem_rdata;
        end
      end
    end
  end

  assign Inval1   = inval1_q;
  assign Inval2   = inval2_q;
  assign ovf      = ovf_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_vadd16_operand_loader.sv
// tb/tb_vadd16_operand_loader.sv - self-checking bench for vadd16_operand_loader
module tb_vadd16_operand_loader;

  logic         clk = 1'b0;
  logic         rst, go, Overflw, done;
  logic [15:0]  base1, base2, mem_addr, mem_rdata;
  logic         mem_rd, start, busy, ovf, complete;
  logic [255:0] Inval1, Inval2;
  logic         done_tie, done_man;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] rd_log [$];

  typedef struct {
    logic [15:0] b1;
    logic [15:0] b2;
    logic        ov;
    int          dly;
    bit          noise;
    int          exp_cmp;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl [5];

  assign done = done_tie ? start : done_man;

  always #5 clk = ~clk;

  vadd16_operand_loader dut (
    .clk(clk), .rst(rst), .go(go), .base1(base1), .base2(base2),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .Inval1(Inval1), .Inval2(Inval2), .start(start), .done(done),
    .Overflw(Overflw), .busy(busy), .ovf(ovf), .complete(complete)
  );

  // synchronous memory: data one cycle after the strobe, junk otherwise
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 16'($urandom);

  always @(negedge clk) if (mem_rd) rd_log.push_back(mem_addr);

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_load(input logic [15:0] b1, input logic [15:0] b2, input logic ov,
                          input int dly, input bit noise, input int exp_cmp, input logic exp_ovf);
    int t_start, t_cmp;
    logic [255:0] e1, e2, h1, h2;
    logic [15:0] a;
    bit stable;
    for (int i = 0; i < 16; i++) begin
      a = b1 + 16'(i);
      e1[i*16 +: 16] = mem[a];
      a = b2 + 16'(i);
      e2[i*16 +: 16] = mem[a];
    end
    @(negedge clk);
    rd_log.delete();
    base1 = b1; base2 = b2; go = 1'b1; Overflw = ov;
    done_tie = (dly == 0); done_man = 1'b0;
    @(negedge clk);
    go = 1'b0; base1 = 16'($urandom); base2 = 16'($urandom);
    t_start = -1; t_cmp = -1; stable = 1'b1;
    h1 = '0; h2 = '0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 1) begin
        check("ovf_cleared_after_go", ovf, 0);
        check("busy_in_c1", busy, 1);
      end
      if (start) begin
        if (t_start < 0) begin
          t_start = c; h1 = Inval1; h2 = Inval2;
        end else if (Inval1 !== h1 || Inval2 !== h2) begin
          stable = 1'b0;
        end
      end
      if (complete) begin
        t_cmp = c;
        check("busy_at_complete", busy, 0);
        check("start_at_complete", start, 0);
        break;
      end
      go = (noise && c < 32) ? 1'($urandom) : 1'b0;
      if (!done_tie && t_start >= 0 && c == t_start + dly) done_man = 1'b1;
      @(negedge clk);
    end
    done_man = 1'b0;
    go = 1'b0;
    check("start_cycle", 32'(t_start), 32'd34);
    check("complete_cycle", 32'(t_cmp), 32'(exp_cmp));
    check("inval_stable_while_start", stable, 1);
    check("ovf_latched", ovf, exp_ovf);
    check("inval1_data", Inval1, e1);
    check("inval2_data", Inval2, e2);
    check("read_count", rd_log.size(), 32);
    for (int i = 0; i < 32 && i < rd_log.size(); i++) begin
      a = (i < 16) ? b1 + 16'(i) : b2 + 16'(i - 16);
      check($sformatf("rd_addr_%0d", i), rd_log[i], a);
    end
    @(negedge clk);
    check("complete_single_pulse", complete, 0);
    check("ovf_held", ovf, exp_ovf);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, nc;
    rst = 1'b1; go = 1'b0; base1 = '0; base2 = '0; Overflw = 1'b0;
    done_tie = 1'b1; done_man = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a);

    tbl[0] = '{16'h0100, 16'h0200, 1'b0, 0, 1'b0, 35, 1'b0};
    tbl[1] = '{16'h0100, 16'h0200, 1'b1, 0, 1'b0, 35, 1'b1};
    tbl[2] = '{16'hFFF8, 16'h1234, 1'b0, 0, 1'b0, 35, 1'b0};
    tbl[3] = '{16'h0300, 16'h0310, 1'b1, 5, 1'b1, 40, 1'b1};
    tbl[4] = '{16'h4000, 16'h4000, 1'b0, 2, 1'b1, 37, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_inval1", Inval1, 0);
    check("rst_inval2", Inval2, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_complete", complete, 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++)
      run_load(tbl[v].b1, tbl[v].b2, tbl[v].ov, tbl[v].dly, tbl[v].noise,
               tbl[v].exp_cmp, tbl[v].exp_ovf);

    // reset in the middle of FETCH
    @(negedge clk);
    base1 = 16'h0500; base2 = 16'h0600; go = 1'b1; done_tie = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_mem_rd", mem_rd, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_inval1", Inval1, 0);
    check("midrst_inval2", Inval2, 0);
    check("midrst_start", start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_complete", complete, 0);
    nc = 0;
    repeat (40) begin
      @(negedge clk);
      if (complete) nc++;
    end
    check("no_complete_after_rst", nc, 0);
    run_load(16'h0500, 16'h0600, 1'b1, 0, 1'b0, 35, 1'b1);

    // back-to-back loads with go held high
    @(negedge clk);
    rd_log.delete();
    base1 = 16'h0A00; base2 = 16'h0B00; go = 1'b1; done_tie = 1'b1; Overflw = 1'b0;
    t1 = -1; t2 = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (complete) begin
        if (t1 < 0) t1 = c;
        else begin
          t2 = c; go = 1'b0;
          break;
        end
      end
      if (t1 > 0 && c == t1 + 1) check("refetch_after_complete", mem_rd, 1);
    end
    go = 1'b0;
    check("b2b_first_complete", 32'(t1), 32'd35);
    check("b2b_second_complete", 32'(t2), 32'd70);
    repeat (2) @(negedge clk);
    check("b2b_idle", busy, 0);
    check("b2b_read_count", rd_log.size(), 64);

    // randomized loads against the memory model
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    for (int r = 0; r < 4; r++) begin
      logic [15:0] rb1, rb2;
      logic rov;
      int rdly;
      rb1 = 16'($urandom); rb2 = 16'($urandom);
      rov = 1'($urandom); rdly = $urandom_range(0, 3);
      run_load(rb1, rb2, rov, rdly, 1'b1, 35 + rdly, rov);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
